// File: rtl/bcd_scan_display_ctrl.sv
// 8-bit binary to 3-digit BCD converter (shift-add-3) with a multiplexed active-low 7-seg scanner.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zeros on the hundreds and tens digits.
module bcd_scan_display_ctrl #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [11:0] bcd,
    output logic        conv_done,
    output logic [6:0]  seg_n,
    output logic [2:0]  dig_n
);

    localparam int unsigned PW = $clog2(SCAN_DIV);

    typedef enum logic {StIdle, StConv} state_e;

    state_e        state_q, state_d;
    logic [19:0]   sreg_q, sreg_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [11:0]   bcd_q, bcd_d;
    logic          done_q, done_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    dig_q, dig_d;

    logic [19:0]   adj;
    logic [19:0]   shifted;
    logic          wrap;
    logic [3:0]    nib;
    logic          blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // One double-dabble step: correct every BCD nibble, then shift left.
    always_comb begin
        adj = sreg_q;
        for (int i = 0; i < 3; i++) begin
            if (adj[8+4*i +: 4] >= 4'd5) begin
                adj[8+4*i +: 4] = adj[8+4*i +: 4] + 4'd3;
            end
        end
        shifted = adj << 1;
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sreg_d  = {12'b0, in_data};
                    cnt_d   = 3'd0;
                    state_d = StConv;
                end
            end
            StConv: begin
                sreg_d = shifted;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    bcd_d   = shifted[19:8];
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wrap    = (presc_q == PW'(SCAN_DIV - 1));
        presc_d = wrap ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (wrap) begin
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
    end

    // Outputs follow the registered index and bcd, so segments and enables switch together.
    always_comb begin
        nib   = 4'd0;
        blank = 1'b0;
        case (idx_q)
            2'd0: nib = bcd_q[3:0];
            2'd1: begin
                nib = bcd_q[7:4];
`ifdef LEADING_ZERO_BLANK_EN
                blank = (bcd_q[11:4] == 8'd0);
`endif
            end
            2'd2: begin
                nib = bcd_q[11:8];
`ifdef LEADING_ZERO_BLANK_EN
                blank = (bcd_q[11:8] == 4'd0);
`endif
            end
            default: nib = 4'hF;
        endcase
        seg_d = blank ? 7'h7F : decode(nib);
        dig_d = ~(3'b001 << idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= 7'h40;
            dig_q   <= 3'b110;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign bcd       = bcd_q;
    assign conv_done = done_q;
    assign seg_n     = seg_q;
    assign dig_n     = dig_q;

endmodule
